uart_msg_arbiter: RTL and testbench

- Shares the single uart_tx transmitter between three message sources: fault detection, node/path reports, and status/debug.
- Each source writes bytes into its own small FIFO. The arbiter then serialises bytes to uart_tx with a start/busy handshake and a guaranteed inter-byte gap.
- Sits between Fault_detection, path_mapping and LED/status logic on one side and uart_tx on the other. It replaces the direct msg-to-data wire.

---
 rtl/uart_msg_arbiter.sv | 132 +++++++++++++
 tb/tb_uart_msg_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_msg_arbiter.sv
// uart_msg_arbiter: three per-source byte FIFOs sharing one uart_tx, fault source first, node/status round-robin,
// start/busy handshake with a busy-rise timeout and a forced idle gap between bytes.
module uart_msg_arbiter #(
   parameter int DATA_W       = 8,
   parameter int FIFO_DEPTH   = 4,
   parameter int GAP_CYCLES   = 16,
   parameter int BUSY_TIMEOUT = 64
) (
   input  logic                clk_50M,
   input  logic                reset,
   input  logic [2:0]          req_valid,
   input  logic [3*DATA_W-1:0] req_data,
   output logic [2:0]          req_ready,
   input  logic                tx_busy,
   output logic                tx_start,
   output logic [DATA_W-1:0]   tx_data,
   output logic [1:0]          grant_id,
   output logic [2:0]          overflow,
   output logic                tx_error
);
   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int CMAX = (BUSY_TIMEOUT > GAP_CYCLES) ? BUSY_TIMEOUT : GAP_CYCLES;
   localparam int CW   = $clog2(CMAX + 1);
   localparam logic [AW:0]   PTR_ONE = (AW+1)'(1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   typedef enum logic [2:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE, GAP} state_t;

   state_t            state, state_d;
   logic [DATA_W-1:0] mem [3][FIFO_DEPTH];
   logic [AW:0]       wr_ptr [3];
   logic [AW:0]       rd_ptr [3];
   logic [DATA_W-1:0] head [3];
   logic [2:0]        empty, push, pop;
   logic [CW-1:0]     cnt, cnt_d;
   logic [1:0]        win, grant_d;
   logic              rr, grant_now, err_set;

   for (genvar i = 0; i < 3; i++) begin : g_fifo
      assign empty[i]     = wr_ptr[i] == rd_ptr[i];
      assign req_ready[i] = !((wr_ptr[i][AW] != rd_ptr[i][AW]) && (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]));
      assign push[i]      = req_valid[i] && req_ready[i];
      assign pop[i]       = (state == LOAD) && (grant_id == 2'(i));
      assign head[i]      = mem[i][rd_ptr[i][AW-1:0]];
      always_ff @(posedge clk_50M)
         if (push[i]) mem[i][wr_ptr[i][AW-1:0]] <= req_data[i*DATA_W +: DATA_W];
   end

   always_ff @(posedge clk_50M or posedge reset)
      if (reset)
         for (int i = 0; i < 3; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
         end
      else
         for (int i = 0; i < 3; i++) begin
            if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_ONE;
            if (pop[i]) rd_ptr[i] <= rd_ptr[i] + PTR_ONE;
         end

   // rr = 0 prefers node (1), rr = 1 prefers status (2); a lone non-empty source wins regardless
   always_comb begin
      win       = !empty[0] ? 2'd0 :
                  (!empty[1] && !empty[2]) ? (rr ? 2'd2 : 2'd1) :
                  !empty[1] ? 2'd1 : 2'd2;
      state_d   = state;
      cnt_d     = cnt;
      grant_d   = grant_id;
      grant_now = 1'b0;
      err_set   = 1'b0;
      case (state)
         IDLE:
            if (!(&empty)) begin
               grant_now = 1'b1;
               grant_d   = win;
               state_d   = LOAD;
            end
         LOAD: begin
            cnt_d   = '0;
            state_d = WAIT_BUSY;
         end
         WAIT_BUSY:
            if (tx_busy) begin
               cnt_d   = '0;
               state_d = WAIT_DONE;
            end else if (cnt == CW'(BUSY_TIMEOUT - 1)) begin
               cnt_d   = '0;
               err_set = 1'b1;
               state_d = GAP;
            end else
               cnt_d = cnt + CNT_ONE;
         WAIT_DONE:
            if (!tx_busy) begin
               cnt_d   = '0;
               state_d = GAP;
            end
         GAP:
            if (GAP_CYCLES == 0 || cnt == CW'(GAP_CYCLES - 1)) begin
               grant_d = 2'd3;
               state_d = IDLE;
            end else
               cnt_d = cnt + CNT_ONE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_50M or posedge reset)
      if (reset) state <= IDLE;
      else state <= state_d;

   // tx_data is captured from the winner's head at grant so it is already valid while tx_start pulses in LOAD
   always_ff @(posedge clk_50M or posedge reset)
      if (reset) begin
         cnt      <= '0;
         grant_id <= 2'd3;
         tx_start <= 1'b0;
         tx_data  <= '0;
         rr       <= 1'b0;
         tx_error <= 1'b0;
         overflow <= '0;
      end else begin
         cnt      <= cnt_d;
         grant_id <= grant_d;
         tx_start <= grant_now;
         tx_error <= tx_error | err_set;
         overflow <= overflow | (req_valid & ~req_ready);
         if (grant_now) begin
            tx_data <= head[win];
            if (win != 2'd0) rr <= ~rr;
         end
      end
endmodule

// File: tb/tb_uart_msg_arbiter.sv
// tb_uart_msg_arbiter: directed vectors against hand-computed transmit order, timing windows and flag values.
module tb_uart_msg_arbiter;
   logic        clk_50M = 1'b0;
   logic        reset = 1'b1;
   logic [2:0]  req_valid = '0;
   logic [23:0] req_data = '0;
   logic [2:0]  req_ready;
   logic        tx_busy;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic [1:0]  grant_id;
   logic [2:0]  overflow;
   logic        tx_error;

   int checks = 0;
   int failures = 0;
   int bmode = 0;
   int busy_d = 0;
   int busy_h = 0;
   logic [7:0] sent [$];
   logic [1:0] gids [$];

   uart_msg_arbiter dut (
      .clk_50M(clk_50M), .reset(reset), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
      .grant_id(grant_id), .overflow(overflow), .tx_error(tx_error)
   );

   initial forever #5 clk_50M = ~clk_50M;

   // uart_tx stand-in: auto mode raises busy 2 cycles after tx_start for 10 cycles; 1 = stuck high, 2 = stuck low
   initial begin
      tx_busy = 1'b0;
      forever begin
         @(posedge clk_50M);
         #2;
         if (reset || bmode != 0) begin
            busy_d = 0;
            busy_h = 0;
         end
         if (reset) tx_busy = 1'b0;
         else if (bmode == 1) tx_busy = 1'b1;
         else if (bmode == 2) tx_busy = 1'b0;
         else begin
            if (busy_h > 0) busy_h--;
            if (busy_d > 0) begin
               busy_d--;
               if (busy_d == 0) busy_h = 10;
            end
            if (tx_start) busy_d = 2;
            tx_busy = busy_h > 0;
         end
      end
   end

   initial forever begin
      @(negedge clk_50M);
      if (tx_start && !reset) begin
         sent.push_back(tx_data);
         gids.push_back(grant_id);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic push(input int i, input logic [7:0] b);
      @(negedge clk_50M);
      req_valid[i] = 1'b1;
      req_data[i*8 +: 8] = b;
      @(negedge clk_50M);
      req_valid = '0;
   endtask

   task automatic wait_sent(input int n, input int budget);
      int k = 0;
      while (sent.size() < n && k < budget) begin
         @(negedge clk_50M);
         k++;
      end
      chk("wait_sent", sent.size(), n);
   endtask

   task automatic do_reset();
      @(negedge clk_50M);
      reset = 1'b1;
      @(negedge clk_50M);
      @(negedge clk_50M);
      reset = 1'b0;
   endtask

   initial begin
      int k;
      logic [7:0] exp_b [5];
      logic [1:0] exp_g [5];

      repeat (3) @(negedge clk_50M);
      chk("rst_tx_start", tx_start, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_grant", grant_id, 3);
      chk("rst_overflow", overflow, 0);
      chk("rst_tx_error", tx_error, 0);
      chk("rst_ready", req_ready, 3'b111);
      reset = 1'b0;
      repeat (2) @(negedge clk_50M);

      // single byte: tx_start 2 cycles after the push edge, gap of 16 cycles after busy falls
      sent.delete(); gids.delete();
      req_valid[1] = 1'b1;
      req_data[15:8] = 8'hA5;
      k = 0;
      while (k < 20) begin
         @(negedge clk_50M);
         k++;
         if (k == 1) req_valid = '0;
         if (tx_start) break;
      end
      chk("single_latency", k, 2);
      chk("single_data", tx_data, 8'hA5);
      chk("single_grant", grant_id, 1);
      k = 0;
      while (!tx_busy && k < 20) begin @(negedge clk_50M); k++; end
      k = 0;
      while (tx_busy && k < 30) begin @(negedge clk_50M); k++; end
      k = 0;
      while (grant_id != 2'd3 && k < 40) begin @(negedge clk_50M); k++; end
      chk("single_gap_window", (k >= 16 && k <= 18), 1);
      chk("single_one_pulse", sent.size(), 1);

      // priority: fault byte pushed mid-frame jumps ahead of the node/status round-robin
      do_reset();
      sent.delete(); gids.delete();
      @(negedge clk_50M);
      req_valid = 3'b110;
      req_data = {8'h21, 8'h11, 8'h00};
      @(negedge clk_50M);
      req_data = {8'h22, 8'h12, 8'h00};
      @(negedge clk_50M);
      req_valid = '0;
      wait_sent(1, 20);
      push(0, 8'hF0);
      wait_sent(5, 400);
      exp_b = '{8'h11, 8'hF0, 8'h21, 8'h12, 8'h22};
      exp_g = '{2'd1, 2'd0, 2'd2, 2'd1, 2'd2};
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("prio_byte%0d", i), (i < sent.size()) ? sent[i] : 8'hxx, exp_b[i]);
         chk($sformatf("prio_gid%0d", i), (i < gids.size()) ? gids[i] : 2'bxx, exp_g[i]);
      end

      // full/overflow: arbiter held in WAIT_DONE while status source pushes 6 bytes
      k = 0;
      while (grant_id != 2'd3 && k < 60) begin @(negedge clk_50M); k++; end
      sent.delete(); gids.delete();
      bmode = 1;
      push(0, 8'hAA);
      wait_sent(1, 20);
      repeat (3) @(negedge clk_50M);
      for (int i = 1; i <= 6; i++) begin
         req_valid[2] = 1'b1;
         req_data[23:16] = 8'(i);
         @(negedge clk_50M);
      end
      req_valid = '0;
      chk("full_ready", req_ready, 3'b011);
      chk("full_overflow", overflow, 3'b100);
      bmode = 0;
      wait_sent(5, 300);
      for (int i = 1; i < 5; i++)
         chk($sformatf("full_byte%0d", i), (i < sent.size()) ? sent[i] : 8'hxx, 8'(i));
      repeat (60) @(negedge clk_50M);
      chk("full_no_extra", sent.size(), 5);
      chk("full_overflow_sticky", overflow, 3'b100);
      chk("full_ready_back", req_ready, 3'b111);

      // timeout: busy never rises, error after about BUSY_TIMEOUT cycles, next byte goes normally
      sent.delete(); gids.delete();
      chk("to_err_before", tx_error, 0);
      bmode = 2;
      push(1, 8'h33);
      wait_sent(1, 20);
      k = 0;
      while (!tx_error && k < 100) begin @(negedge clk_50M); k++; end
      chk("to_err_window", (k >= 63 && k <= 66), 1);
      k = 0;
      while (grant_id != 2'd3 && k < 40) begin @(negedge clk_50M); k++; end
      chk("to_idle", grant_id, 3);
      bmode = 0;
      push(2, 8'h44);
      wait_sent(2, 40);
      chk("to_next_byte", (sent.size() > 1) ? sent[1] : 8'hxx, 8'h44);
      chk("to_next_gid", (gids.size() > 1) ? gids[1] : 2'bxx, 2);
      chk("to_err_sticky", tx_error, 1);

      // wrap-around: 10 fault bytes through a 4-deep FIFO
      sent.delete(); gids.delete();
      for (int i = 0; i < 10; i++) begin
         push(0, 8'h80 + 8'(i));
         wait_sent(i + 1, 80);
      end
      for (int i = 0; i < 10; i++)
         chk($sformatf("wrap_byte%0d", i), (i < sent.size()) ? sent[i] : 8'hxx, 8'h80 + 8'(i));

      // reset mid-frame with bytes still queued
      k = 0;
      while (grant_id != 2'd3 && k < 60) begin @(negedge clk_50M); k++; end
      sent.delete(); gids.delete();
      @(negedge clk_50M);
      req_valid = 3'b110;
      req_data = {8'h61, 8'h51, 8'h00};
      @(negedge clk_50M);
      req_valid = 3'b010;
      req_data[15:8] = 8'h52;
      @(negedge clk_50M);
      req_data[15:8] = 8'h53;
      @(negedge clk_50M);
      req_valid = '0;
      wait_sent(1, 20);
      k = 0;
      while (!tx_busy && k < 20) begin @(negedge clk_50M); k++; end
      repeat (2) @(negedge clk_50M);
      chk("mid_ready_before", req_ready, 3'b111);
      chk("mid_grant_before", grant_id == 2'd3, 0);
      #2 reset = 1'b1;
      #1;
      chk("mid_tx_start", tx_start, 0);
      chk("mid_tx_data", tx_data, 0);
      chk("mid_grant", grant_id, 3);
      chk("mid_overflow", overflow, 0);
      chk("mid_tx_error", tx_error, 0);
      chk("mid_ready", req_ready, 3'b111);
      repeat (3) @(negedge clk_50M);
      reset = 1'b0;
      sent.delete();
      repeat (60) @(negedge clk_50M);
      chk("mid_no_start", sent.size(), 0);
      chk("mid_idle_grant", grant_id, 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
